// File: rtl/ts_loss_monitor.sv
// ts_loss_monitor: N-channel MPEG2-TS ingest monitor.
// Per channel: 0x47 sync acquisition/tracking, single-PID filter,
// continuity-counter check, saturating packet/loss counters, all readable
// through a small registered memory-mapped interface (channel c at 16*c).
// Optional build macro TS_TEI_DROP_EN: matching packets flagged with TEI=1
// are excluded from the CC check and counted in STATUS[23:16].
module ts_loss_monitor #(
    parameter int NUM_CH   = 4,
    parameter int PKT_LEN  = 188,
    parameter int CNT_W    = 16,
    parameter int MISS_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ts_valid,
    input  logic [8*NUM_CH-1:0] ts_data,
    input  logic                mm_write_en,
    input  logic                mm_read_en,
    input  logic [7:0]          mm_addr,
    input  logic [31:0]         mm_wdata,
    output logic [31:0]         mm_rdata,
    output logic [NUM_CH-1:0]   lock,
    output logic [NUM_CH-1:0]   loss_pulse
);

    localparam int BCNT_W = $clog2(PKT_LEN);
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(PKT_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
    localparam logic [7:0]        SYNC      = 8'h47;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t              state_q   [NUM_CH];
    state_t              state_d   [NUM_CH];
    logic [BCNT_W-1:0]   bcnt_q    [NUM_CH];
    logic [BCNT_W-1:0]   bcnt_d    [NUM_CH];
    logic [MISS_W-1:0]   miss_q    [NUM_CH];
    logic [MISS_W-1:0]   miss_d    [NUM_CH];
    logic                en_q      [NUM_CH];
    logic                en_d      [NUM_CH];
    logic [12:0]         pid_q     [NUM_CH];
    logic [12:0]         pid_d     [NUM_CH];
    logic [CNT_W-1:0]    pkt_q     [NUM_CH];
    logic [CNT_W-1:0]    pkt_d     [NUM_CH];
    logic [CNT_W-1:0]    loss_q    [NUM_CH];
    logic [CNT_W-1:0]    loss_d    [NUM_CH];
    logic [7:0]          serr_q    [NUM_CH];
    logic [7:0]          serr_d    [NUM_CH];
    logic [3:0]          last_cc_q [NUM_CH];
    logic [3:0]          last_cc_d [NUM_CH];
    logic                first_q   [NUM_CH];
    logic                first_d   [NUM_CH];
    logic [4:0]          pid_hi_q  [NUM_CH];
    logic [4:0]          pid_hi_d  [NUM_CH];
    logic [7:0]          pid_lo_q  [NUM_CH];
    logic [7:0]          pid_lo_d  [NUM_CH];
`ifdef TS_TEI_DROP_EN
    logic                tei_q     [NUM_CH];
    logic                tei_d     [NUM_CH];
    logic [7:0]          tei_cnt_q [NUM_CH];
    logic [7:0]          tei_cnt_d [NUM_CH];
`endif
    logic [NUM_CH-1:0]   lock_q, lock_d;
    logic [NUM_CH-1:0]   pulse_q, pulse_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [3:0]          addr_ch;
    logic [1:0]          addr_reg;
    logic                addr_hit;
    logic                unused_wdata;

    // Channel base is addr[7:4]; registers sit at offsets 0x0/0x4/0x8/0xC.
    assign addr_ch      = mm_addr[7:4];
    assign addr_reg     = mm_addr[3:2];
    assign addr_hit     = (mm_addr[1:0] == 2'b00) && (int'(addr_ch) < NUM_CH);
    assign unused_wdata = ^mm_wdata[31:14];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction

    // Per-channel sync tracking, header capture, CC check and register writes.
    always_comb begin
        logic [7:0]        b;
        logic [BCNT_W-1:0] bnext;
        logic [3:0]        diff;
        logic              wr_sel;
        logic              check;
        for (int c = 0; c < NUM_CH; c++) begin
            b      = ts_data[8*c +: 8];
            bnext  = (bcnt_q[c] == BCNT_LAST) ? '0 : bcnt_q[c] + 1'b1;
            diff   = b[3:0] - last_cc_q[c];
            wr_sel = mm_write_en && addr_hit && (int'(addr_ch) == c);
            check  = 1'b1;

            state_d[c]   = state_q[c];
            bcnt_d[c]    = bcnt_q[c];
            miss_d[c]    = miss_q[c];
            en_d[c]      = en_q[c];
            pid_d[c]     = pid_q[c];
            pkt_d[c]     = pkt_q[c];
            loss_d[c]    = loss_q[c];
            serr_d[c]    = serr_q[c];
            last_cc_d[c] = last_cc_q[c];
            first_d[c]   = first_q[c];
            pid_hi_d[c]  = pid_hi_q[c];
            pid_lo_d[c]  = pid_lo_q[c];
`ifdef TS_TEI_DROP_EN
            tei_d[c]     = tei_q[c];
            tei_cnt_d[c] = tei_cnt_q[c];
`endif
            pulse_d[c]   = 1'b0;

            if (ts_valid[c]) begin
                bcnt_d[c] = bnext;
                case (state_q[c])
                    HUNT: begin
                        if (b == SYNC) begin
                            state_d[c] = VERIFY;
                            bcnt_d[c]  = BCNT_W'(1);
                        end else begin
                            bcnt_d[c]  = '0;
                        end
                    end
                    VERIFY: begin
                        if (bcnt_q[c] == '0) begin
                            if (b == SYNC) begin
                                state_d[c] = LOCK;
                                miss_d[c]  = '0;
                                first_d[c] = 1'b1;
                            end else begin
                                state_d[c] = HUNT;
                                bcnt_d[c]  = '0;
                            end
                        end
                    end
                    LOCK: begin
                        if (bcnt_q[c] == '0) begin
                            if (b == SYNC) begin
                                miss_d[c] = '0;
                            end else if (miss_q[c] == MISS_LAST) begin
                                state_d[c] = HUNT;
                                bcnt_d[c]  = '0;
                                miss_d[c]  = '0;
                                serr_d[c]  = sat_inc8(serr_q[c]);
                            end else begin
                                miss_d[c] = miss_q[c] + 1'b1;
                            end
                        end
                        if (bcnt_q[c] == BCNT_W'(1)) begin
                            pid_hi_d[c] = b[4:0];
`ifdef TS_TEI_DROP_EN
                            tei_d[c]    = b[7];
`endif
                        end
                        if (bcnt_q[c] == BCNT_W'(2)) begin
                            pid_lo_d[c] = b;
                        end
                        // Byte 3 completes the header: filter, count, CC check.
                        if (bcnt_q[c] == BCNT_W'(3) && en_q[c] &&
                            {pid_hi_q[c], pid_lo_q[c]} == pid_q[c]) begin
                            pkt_d[c] = sat_add(pkt_q[c], 4'd1);
                            if (b[4]) begin
`ifdef TS_TEI_DROP_EN
                                if (tei_q[c]) begin
                                    check        = 1'b0;
                                    tei_cnt_d[c] = sat_inc8(tei_cnt_q[c]);
                                end
`endif
                                if (check) begin
                                    if (first_q[c]) begin
                                        first_d[c] = 1'b0;
                                    end else if (diff > 4'd1) begin
                                        loss_d[c]  = sat_add(loss_q[c], diff - 4'd1);
                                        pulse_d[c] = 1'b1;
                                    end
                                    last_cc_d[c] = b[3:0];
                                end
                            end
                        end
                    end
                    default: begin
                        state_d[c] = HUNT;
                        bcnt_d[c]  = '0;
                    end
                endcase
            end

            // Register writes come last so a clear beats a same-cycle increment.
            if (wr_sel) begin
                case (addr_reg)
                    2'd0: begin
                        en_d[c]    = mm_wdata[13];
                        pid_d[c]   = mm_wdata[12:0];
                        first_d[c] = 1'b1;
                    end
                    2'd1: pkt_d[c]  = '0;
                    2'd2: loss_d[c] = '0;
                    default: begin
                        serr_d[c] = '0;
`ifdef TS_TEI_DROP_EN
                        tei_cnt_d[c] = '0;
`endif
                    end
                endcase
            end

            lock_d[c] = (state_d[c] == LOCK);
        end
    end

    // Read mux: capture the addressed register only when a read is strobed.
    always_comb begin
        rdata_d = rdata_q;
        if (mm_read_en) begin
            rdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr_hit && int'(addr_ch) == c) begin
                    case (addr_reg)
                        2'd0:    rdata_d = {18'd0, en_q[c], pid_q[c]};
                        2'd1:    rdata_d = 32'(pkt_q[c]);
                        2'd2:    rdata_d = 32'(loss_q[c]);
`ifdef TS_TEI_DROP_EN
                        default: rdata_d = {8'd0, tei_cnt_q[c], serr_q[c], 5'd0,
                                            state_q[c], lock_q[c]};
`else
                        default: rdata_d = {8'd0, 8'd0, serr_q[c], 5'd0,
                                            state_q[c], lock_q[c]};
`endif
                    endcase
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= HUNT;
                bcnt_q[c]    <= '0;
                miss_q[c]    <= '0;
                en_q[c]      <= 1'b0;
                pid_q[c]     <= 13'h1FFF;
                pkt_q[c]     <= '0;
                loss_q[c]    <= '0;
                serr_q[c]    <= '0;
                last_cc_q[c] <= '0;
                first_q[c]   <= 1'b1;
                pid_hi_q[c]  <= '0;
                pid_lo_q[c]  <= '0;
`ifdef TS_TEI_DROP_EN
                tei_q[c]     <= 1'b0;
                tei_cnt_q[c] <= '0;
`endif
            end
            lock_q  <= '0;
            pulse_q <= '0;
            rdata_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= state_d[c];
                bcnt_q[c]    <= bcnt_d[c];
                miss_q[c]    <= miss_d[c];
                en_q[c]      <= en_d[c];
                pid_q[c]     <= pid_d[c];
                pkt_q[c]     <= pkt_d[c];
                loss_q[c]    <= loss_d[c];
                serr_q[c]    <= serr_d[c];
                last_cc_q[c] <= last_cc_d[c];
                first_q[c]   <= first_d[c];
                pid_hi_q[c]  <= pid_hi_d[c];
                pid_lo_q[c]  <= pid_lo_d[c];
`ifdef TS_TEI_DROP_EN
                tei_q[c]     <= tei_d[c];
                tei_cnt_q[c] <= tei_cnt_d[c];
`endif
            end
            lock_q  <= lock_d;
            pulse_q <= pulse_d;
            rdata_q <= rdata_d;
        end
    end

    assign mm_rdata   = rdata_q;
    assign lock       = lock_q;
    assign loss_pulse = pulse_q;

endmodule

// File: tb/tb_ts_loss_monitor.sv
// Bench for ts_loss_monitor: directed packet streams, a packet-level
// reference model compared every cycle, and hand-computed register values.
module tb_ts_loss_monitor;

    localparam int NCH      = 4;
    localparam int PKT      = 188;
    localparam int MISS_MAX = 3;
    localparam int MAXC     = 65535;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     ts_valid;
    logic [8*NCH-1:0]   ts_data;
    logic               mm_write_en;
    logic               mm_read_en;
    logic [7:0]         mm_addr;
    logic [31:0]        mm_wdata;
    logic [31:0]        mm_rdata;
    logic [NCH-1:0]     lock;
    logic [NCH-1:0]     loss_pulse;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    ts_loss_monitor #(.NUM_CH(NCH), .PKT_LEN(PKT), .CNT_W(16), .MISS_MAX(MISS_MAX)) dut (
        .clk(clk), .rst(rst), .ts_valid(ts_valid), .ts_data(ts_data),
        .mm_write_en(mm_write_en), .mm_read_en(mm_read_en), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .lock(lock), .loss_pulse(loss_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (packet-level view) ----------------
    int m_st [NCH];   // 0 hunting, 1 verifying, 2 locked
    int m_pos [NCH];  // byte offset in current packet
    int m_miss [NCH];
    int m_en [NCH];
    int m_pid [NCH];
    int m_pkt [NCH];
    int m_loss [NCH];
    int m_serr [NCH];
    int m_teic [NCH];
    int m_last [NCH];
    int m_first [NCH];
    int m_h1 [NCH];
    int m_h2 [NCH];
    int m_teib [NCH];
    logic [NCH-1:0] m_lock;
    logic [NCH-1:0] m_pulse;
    logic [31:0]    m_rdata;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c] = 0; m_pos[c] = 0; m_miss[c] = 0; m_en[c] = 0; m_pid[c] = 'h1FFF;
            m_pkt[c] = 0; m_loss[c] = 0; m_serr[c] = 0; m_teic[c] = 0; m_last[c] = 0;
            m_first[c] = 1; m_h1[c] = 0; m_h2[c] = 0; m_teib[c] = 0;
        end
        m_lock = '0; m_pulse = '0; m_rdata = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int c, off;
        c = int'(a) / 16;
        off = int'(a) % 16;
        if (c >= NCH) return 32'd0;
        case (off)
            0:  return 32'(m_en[c] * 8192 + m_pid[c]);
            4:  return 32'(m_pkt[c]);
            8:  return 32'(m_loss[c]);
            12: return 32'(m_teic[c] * 65536 + m_serr[c] * 256 + m_st[c] * 2 + int'(m_lock[c]));
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int c, off;
        c = int'(a) / 16;
        off = int'(a) % 16;
        if (c < NCH) begin
            case (off)
                0:  begin m_en[c] = int'(d[13]); m_pid[c] = int'(d[12:0]); m_first[c] = 1; end
                4:  m_pkt[c] = 0;
                8:  m_loss[c] = 0;
                12: begin m_serr[c] = 0; m_teic[c] = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic model_hdr(input int c, input logic [7:0] b);
        int cc, d, skip;
        cc = int'(b[3:0]);
        skip = 0;
        if (m_en[c] != 0 && (m_h1[c] * 256 + m_h2[c]) == m_pid[c]) begin
            m_pkt[c] = (m_pkt[c] < MAXC) ? m_pkt[c] + 1 : MAXC;
            if (b[5:4] == 2'b01 || b[5:4] == 2'b11) begin
`ifdef TS_TEI_DROP_EN
                if (m_teib[c] != 0) begin
                    skip = 1;
                    if (m_teic[c] < 255) m_teic[c]++;
                end
`endif
                if (skip == 0) begin
                    if (m_first[c] != 0) begin
                        m_first[c] = 0;
                    end else begin
                        d = (cc - m_last[c] + 16) % 16;
                        if (d >= 2) begin
                            m_loss[c] = (m_loss[c] + d - 1 > MAXC) ? MAXC : m_loss[c] + d - 1;
                            m_pulse[c] = 1'b1;
                        end
                    end
                    m_last[c] = cc;
                end
            end
        end
    endtask

    task automatic model_byte(input int c, input logic [7:0] b);
        if (m_st[c] == 0) begin
            if (b == 8'h47) begin m_st[c] = 1; m_pos[c] = 1; end
        end else begin
            if (m_pos[c] == 0) begin
                if (m_st[c] == 1) begin
                    if (b == 8'h47) begin m_st[c] = 2; m_first[c] = 1; m_miss[c] = 0; end
                    else m_st[c] = 0;
                end else if (b == 8'h47) begin
                    m_miss[c] = 0;
                end else begin
                    m_miss[c]++;
                    if (m_miss[c] == MISS_MAX) begin
                        m_st[c] = 0; m_miss[c] = 0;
                        if (m_serr[c] < 255) m_serr[c]++;
                    end
                end
            end else if (m_st[c] == 2) begin
                if (m_pos[c] == 1) begin m_h1[c] = int'(b[4:0]); m_teib[c] = int'(b[7]); end
                if (m_pos[c] == 2) m_h2[c] = int'(b);
                if (m_pos[c] == 3) model_hdr(c, b);
            end
            m_pos[c] = (m_st[c] == 0) ? 0 : (m_pos[c] + 1) % PKT;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            if (mm_read_en) m_rdata = model_read(mm_addr);
            for (int c = 0; c < NCH; c++) begin
                m_pulse[c] = 1'b0;
                if (ts_valid[c]) model_byte(c, ts_data[8*c +: 8]);
                m_lock[c] = (m_st[c] == 2);
            end
            if (mm_write_en) model_write(mm_addr, mm_wdata);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("lock", 32'(lock), 32'(m_lock));
            check("loss_pulse", 32'(loss_pulse), 32'(m_pulse));
            check("mm_rdata", mm_rdata, m_rdata);
        end
    end

    int p1 = 0;
    always @(negedge clk) if (loss_pulse[1]) p1++;

    // ---------------- stimulus ----------------
    logic [7:0]  d_sync [NCH];
    logic [12:0] d_pid  [NCH];
    logic        d_tei  [NCH];
    logic [1:0]  d_afc  [NCH];
    logic [3:0]  d_cc   [NCH];
    logic [NCH-1:0] lock_b0;

    task automatic set_d(input int c, input logic [7:0] s, input logic [12:0] p,
                         input logic t, input logic [3:0] cc);
        d_sync[c] = s; d_pid[c] = p; d_tei[c] = t; d_afc[c] = 2'b01; d_cc[c] = cc;
    endtask

    function automatic logic [7:0] pkt_byte(input int c, input int i);
        case (i)
            0: return d_sync[c];
            1: return {d_tei[c], 2'b00, d_pid[c][12:8]};
            2: return d_pid[c][7:0];
            3: return {2'b00, d_afc[c], d_cc[c]};
            default: return 8'(i % 64);
        endcase
    endfunction

    task automatic run_pkt(input logic [NCH-1:0] mask, input bit gap,
                           input bit wr_b3, input logic [7:0] wr_addr);
        for (int i = 0; i < PKT; i++) begin
            for (int c = 0; c < NCH; c++) ts_data[8*c +: 8] = pkt_byte(c, i);
            ts_valid = mask;
            if (wr_b3 && i == 3) begin
                mm_write_en = 1'b1; mm_addr = wr_addr; mm_wdata = 32'd0;
            end
            @(negedge clk);
            mm_write_en = 1'b0;
            if (i == 0) lock_b0 = lock;
            if (gap && (i == 1 || i == 2)) begin
                ts_valid = '0;
                ts_data = {NCH{8'h47}};
                @(negedge clk);
            end
        end
        ts_valid = '0;
    endtask

    task automatic mm_wr(input logic [7:0] a, input logic [31:0] d);
        mm_write_en = 1'b1; mm_addr = a; mm_wdata = d;
        @(negedge clk);
        mm_write_en = 1'b0;
    endtask

    task automatic mm_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        mm_read_en = 1'b1; mm_addr = a;
        @(negedge clk);
        mm_read_en = 1'b0;
        check(name, mm_rdata, exp);
    endtask

    int cc1 [5] = '{0, 1, 2, 5, 6};
    int cc2 [3] = '{7, 7, 8};
    int p1_start;

    initial begin
        rst = 1'b1; ts_valid = '0; ts_data = '0;
        mm_write_en = 1'b0; mm_read_en = 1'b0; mm_addr = '0; mm_wdata = '0;
        for (int c = 0; c < NCH; c++) set_d(c, 8'h47, 13'h1FFF, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("reset_lock", 32'(lock), 32'd0);
        mm_rd("reset_cfg0", 8'h00, 32'h0000_1FFF);
        mm_rd("reset_status3", 8'h3C, 32'd0);

        mm_wr(8'h10, 32'h0000_2100);
        mm_wr(8'h20, 32'h0000_2100);

        // Acquire lock on all channels simultaneously
        run_pkt(4'b1111, 1'b0, 1'b0, 8'h00);
        check("no_lock_after_pkt0", 32'(lock[0]), 32'd0);
        run_pkt(4'b1111, 1'b0, 1'b0, 8'h00);
        check("lock_after_pkt1_byte0", 32'(lock_b0[0]), 32'd1);
        run_pkt(4'b1111, 1'b1, 1'b0, 8'h00);
        mm_rd("status0_locked", 8'h0C, 32'h0000_0005);

        // Ch1 CC 0,1,2,5,6 and ch2 CC 7,7,8 in parallel
        p1_start = p1;
        for (int k = 0; k < 5; k++) begin
            set_d(1, 8'h47, 13'h0100, 1'b0, 4'(cc1[k]));
            if (k < 3) set_d(2, 8'h47, 13'h0100, 1'b0, 4'(cc2[k]));
            else       set_d(2, 8'h47, 13'h1FFF, 1'b0, 4'd0);
            run_pkt(4'b1111, (k == 2), 1'b0, 8'h00);
        end
        mm_rd("ch1_loss", 8'h18, 32'd2);
        mm_rd("ch1_pkt", 8'h14, 32'd5);
        check("ch1_pulse_count", 32'(p1 - p1_start), 32'd1);
        mm_rd("ch2_loss_dup", 8'h28, 32'd0);

        // Ch2 wrap 15 -> 0 after a re-arming CFG write
        mm_wr(8'h20, 32'h0000_2100);
        set_d(2, 8'h47, 13'h0100, 1'b0, 4'd15);
        run_pkt(4'b0100, 1'b0, 1'b0, 8'h00);
        set_d(2, 8'h47, 13'h0100, 1'b0, 4'd0);
        run_pkt(4'b0100, 1'b0, 1'b0, 8'h00);
        mm_rd("ch2_loss_wrap", 8'h28, 32'd0);
        mm_rd("ch2_pkt", 8'h24, 32'd5);

        // Loss (6 -> 10) and LOSS_CNT clear in the same cycle
        set_d(1, 8'h47, 13'h0100, 1'b0, 4'd10);
        run_pkt(4'b0010, 1'b0, 1'b1, 8'h18);
        mm_rd("ch1_loss_clear_wins", 8'h18, 32'd0);
        mm_rd("ch1_pkt6", 8'h14, 32'd6);

        // Out-of-range and unmapped addresses
        mm_wr(8'h40, 32'h0000_2100);
        mm_rd("oob_0x40", 8'h40, 32'd0);
        mm_rd("unmapped_0x0E", 8'h0E, 32'd0);

        // Ch3 loses sync after three bad sync bytes, then relocks
        set_d(3, 8'h00, 13'h1FFF, 1'b0, 4'd0);
        run_pkt(4'b1000, 1'b0, 1'b0, 8'h00);
        run_pkt(4'b1000, 1'b0, 1'b0, 8'h00);
        check("ch3_lock_after_2_miss", 32'(lock[3]), 32'd1);
        run_pkt(4'b1000, 1'b0, 1'b0, 8'h00);
        check("ch3_lock_after_3_miss", 32'(lock[3]), 32'd0);
        mm_rd("ch3_status_hunt", 8'h3C, 32'h0000_0100);
        set_d(3, 8'h47, 13'h1FFF, 1'b0, 4'd0);
        run_pkt(4'b1000, 1'b0, 1'b0, 8'h00);
        mm_rd("ch3_status_verify", 8'h3C, 32'h0000_0102);
        run_pkt(4'b1000, 1'b0, 1'b0, 8'h00);
        mm_rd("ch3_status_relock", 8'h3C, 32'h0000_0105);
        mm_wr(8'h3C, 32'd0);
        mm_rd("ch3_status_cleared", 8'h3C, 32'h0000_0005);

        // TEI handling: CC 3, CC 9 with TEI=1, CC 4
        mm_wr(8'h10, 32'h0000_2100);
        mm_wr(8'h18, 32'd0);
        set_d(1, 8'h47, 13'h0100, 1'b0, 4'd3);
        run_pkt(4'b0010, 1'b0, 1'b0, 8'h00);
        set_d(1, 8'h47, 13'h0100, 1'b1, 4'd9);
        run_pkt(4'b0010, 1'b0, 1'b0, 8'h00);
        set_d(1, 8'h47, 13'h0100, 1'b0, 4'd4);
        run_pkt(4'b0010, 1'b0, 1'b0, 8'h00);
`ifdef TS_TEI_DROP_EN
        mm_rd("tei_loss", 8'h18, 32'd0);
        mm_rd("tei_status", 8'h1C, 32'h0001_0005);
`else
        mm_rd("tei_ignored_loss", 8'h18, 32'd15);
        mm_rd("tei_ignored_status", 8'h1C, 32'h0000_0005);
`endif

        // Reset while locked
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_lock", 32'(lock), 32'd0);
        mm_rd("rst_cfg1", 8'h10, 32'h0000_1FFF);
        mm_rd("rst_pkt1", 8'h14, 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
